control_mc: RTL and testbench
=============================

CONTROL_MC -- requirements
Module: control_mc

Interface
REQ-001 Parameter NCH, default 4: number of discriminator channels, 1..16.
REQ-002 Parameter DW, default 8: discriminator threshold width, 4..16.
REQ-003 Parameter LSBZ, default 3: number of threshold LSBs forced to zero, 0..DW-1.
REQ-004 Parameter HOLDOFF, default 16: cycles of fifo_full low required before gating reopens, 1..255.
REQ-005 clock  in  1  single clock; all state changes on its rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 cmd_valid  in  1  host command strobe.
REQ-008 cmd_ready  out  1  command accepted when cmd_valid & cmd_ready are high on a rising edge.
REQ-009 cmd_op  in  3  opcode: 0 NOP, 1 ARM, 2 DISARM, 3 SET_DISC, 4 ARM_ALL, 5 DISARM_ALL, 6 CLR_OVF, 7 reserved.
REQ-010 cmd_chan  in  4  target channel index.
REQ-011 cmd_data  in  DW  threshold value for SET_DISC.
REQ-012 fifo_full  in  1  downstream FIFO full.
REQ-013 disableout  out  NCH  per-channel acquisition disable; 1 = disabled.
REQ-014 discriminator  out  NCH*DW  packed thresholds; channel i occupies bits [i*DW +: DW].
REQ-015 cmd_err  out  1  one-cycle pulse on a rejected command.
REQ-016 ovf_count  out  16  count of fifo_full rising edges while any channel is armed.

Function
REQ-017 cmd_ready SHALL be 0 during reset and on the first clock edge after reset_n deasserts, then 1 permanently.
REQ-018 ARM SHALL set armed[cmd_chan], and DISARM SHALL clear it, on the accepting edge.
REQ-019 ARM_ALL / DISARM_ALL SHALL set / clear all NCH armed bits; cmd_chan is ignored.
REQ-020 SET_DISC SHALL load cmd_data[DW-1:LSBZ] into the upper bits of channel cmd_chan and zeros into its low LSBZ bits, visible the cycle after acceptance.
REQ-021 CLR_OVF SHALL reset ovf_count to 0; a fifo_full rising edge in the same cycle SHALL yield 1.
REQ-022 A channel-addressed op (1, 2, 3) with cmd_chan >= NCH, or op 7, SHALL change no state and SHALL pulse cmd_err for exactly one cycle after acceptance.
REQ-023 A gating FSM SHALL have states RUN, FULL and HOLD.
REQ-024 FSM transitions: RUN->FULL when fifo_full=1; FULL->HOLD when fifo_full=0, loading counter=HOLDOFF-1; HOLD->FULL when fifo_full=1; HOLD->RUN when counter=0 with fifo_full=0, otherwise decrement.
REQ-025 disableout[i] SHALL equal ~(armed[i] & (state==RUN) & ~fifo_full), combinationally from registers and fifo_full, so that fifo_full disables all channels in the same cycle.
REQ-026 ovf_count SHALL increment on each 0->1 transition of registered fifo_full while any armed bit is 1, saturating at 16'hFFFF.
REQ-027 Command processing SHALL be independent of FSM state; arming during FULL/HOLD takes effect when RUN is reached.

Reset
REQ-028 With reset_n low: armed=0, all thresholds=0, FSM=RUN, counter=0, ovf_count=0, cmd_err=0, cmd_ready=0, and disableout therefore all 1s.
REQ-029 Reset asserted mid-HOLD or mid-command SHALL abandon the operation, and no partial update SHALL survive.

Structure
REQ-030 A shared package control_pkg SHALL hold the opcode enumeration, the FSM state enumeration and the OVF_MAX constant.
REQ-031 Per-channel threshold storage SHALL be a sub-module disc_reg (DW, LSBZ), instantiated NCH times.

Verification
REQ-032 Reset release, then ARM ch2 -> disableout = 4'b1011 one cycle later; other outputs remain at reset values.
REQ-033 SET_DISC ch1, data 8'hFF -> discriminator[15:8] = 8'hF8; other channels unchanged.
REQ-034 ARM_ALL, then fifo_full high 5 cycles -> disableout = 4'hF in the same cycle and ovf_count = 1; after fifo_full drops, disableout = 4'hF for exactly 16 cycles, then 4'h0.
REQ-035 fifo_full re-pulsed during HOLD -> FSM returns to FULL, counter restarts on the next fall, and ovf_count = 2.
REQ-036 SET_DISC with cmd_chan=7 (NCH=4) -> cmd_err pulses 1 cycle and no threshold changes; CLR_OVF concurrent with a fifo_full rise -> ovf_count = 1.
REQ-037 Force ovf_count to 16'hFFFF by 65535 pulses, then one more pulse -> ovf_count holds 16'hFFFF.

Source files
------------

// File: rtl/control_pkg.sv
// Shared types and constants for the multichannel acquisition gating controller.
package control_pkg;

    typedef enum logic [2:0] {
        OP_NOP        = 3'd0,
        OP_ARM        = 3'd1,
        OP_DISARM     = 3'd2,
        OP_SET_DISC   = 3'd3,
        OP_ARM_ALL    = 3'd4,
        OP_DISARM_ALL = 3'd5,
        OP_CLR_OVF    = 3'd6,
        OP_RSVD       = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_FULL = 2'd1,
        ST_HOLD = 2'd2
    } gate_st_e;

    localparam logic [15:0] OVF_MAX = 16'hFFFF;

endpackage

// File: rtl/control_mc_if.sv
// Host command channel: valid/ready strobe, opcode, channel, threshold data, error pulse.
interface control_mc_if #(parameter int DW = 8);

    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [3:0]    cmd_chan;
    logic [DW-1:0] cmd_data;
    logic          cmd_err;

    modport master (
        output cmd_valid, cmd_op, cmd_chan, cmd_data,
        input  cmd_ready, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_chan, cmd_data,
        output cmd_ready, cmd_err
    );

endinterface

// File: rtl/disc_reg.sv
// One channel's discriminator threshold; the low LSBZ bits always read as zero.
module disc_reg #(
    parameter int DW   = 8,
    parameter int LSBZ = 3
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          load,
    input  logic [DW-1:0] data,
    output logic [DW-1:0] value
);

    localparam logic [DW-1:0] KEEP = {DW{1'b1}} << LSBZ;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            value <= '0;
        else if (load)
            value <= data & KEEP;
    end

endmodule

// File: rtl/control_mc.sv
// Multichannel acquisition controller: host command decode, per-channel arming and
// thresholds, and a fifo_full gating FSM with a holdoff before acquisition reopens.
//
//   state | meaning
//   RUN   | acquisition open for armed channels
//   FULL  | downstream FIFO full, all channels disabled
//   HOLD  | FIFO drained, counting down holdoff before reopening
module control_mc
    import control_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int DW      = 8,
    parameter int LSBZ    = 3,
    parameter int HOLDOFF = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    control_mc_if.slave       cmd,
    input  logic              fifo_full,
    output logic [NCH-1:0]    disableout,
    output logic [NCH*DW-1:0] discriminator,
    output logic [15:0]       ovf_count
);

    localparam logic [4:0] NCH_W     = 5'(NCH);
    localparam logic [7:0] HOLD_LOAD = 8'(HOLDOFF - 1);

    logic           ready_q, err_q, ff_q;
    logic [NCH-1:0] armed_q, armed_d, sel;
    logic [15:0]    ovf_q, ovf_d;
    gate_st_e       state_q, state_d;
    logic [7:0]     cnt_q, cnt_d;
    op_e            op;
    logic           accept, chan_ok, chan_op, bad, fill_rise, run_open;

    assign op        = op_e'(cmd.cmd_op);
    assign accept    = cmd.cmd_valid & ready_q;
    assign chan_ok   = {1'b0, cmd.cmd_chan} < NCH_W;
    assign chan_op   = (op == OP_ARM) || (op == OP_DISARM) || (op == OP_SET_DISC);
    assign bad       = accept & ((chan_op & ~chan_ok) | (op == OP_RSVD));
    assign fill_rise = fifo_full & ~ff_q & (|armed_q);

    // Out-of-range channels decode to an all-zero select, so they touch nothing.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NCH; i++)
            sel[i] = chan_ok && (cmd.cmd_chan == 4'(i));
    end

    always_comb begin
        armed_d = armed_q;
        if (accept) begin
            case (op)
                OP_ARM:        armed_d = armed_q | sel;
                OP_DISARM:     armed_d = armed_q & ~sel;
                OP_ARM_ALL:    armed_d = '1;
                OP_DISARM_ALL: armed_d = '0;
                default:       armed_d = armed_q;
            endcase
        end
    end

    // A clear that coincides with a new overflow keeps that overflow.
    always_comb begin
        ovf_d = ovf_q;
        if (accept && (op == OP_CLR_OVF))
            ovf_d = fill_rise ? 16'd1 : 16'd0;
        else if (fill_rise && (ovf_q != OVF_MAX))
            ovf_d = ovf_q + 16'd1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            ff_q    <= 1'b0;
            armed_q <= '0;
            ovf_q   <= '0;
        end else begin
            ready_q <= 1'b1;
            err_q   <= bad;
            ff_q    <= fifo_full;
            armed_q <= armed_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN:
                if (fifo_full) state_d = ST_FULL;
            ST_FULL:
                if (!fifo_full) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                end
            ST_HOLD:
                if (fifo_full)
                    state_d = ST_FULL;
                else if (cnt_q == 8'd0)
                    state_d = ST_RUN;
                else
                    cnt_d = cnt_q - 8'd1;
            default:
                state_d = ST_RUN;
        endcase
    end

    // fifo_full gates combinationally so a full FIFO closes every channel at once.
    assign run_open   = (state_q == ST_RUN) && !fifo_full;
    assign disableout = ~(armed_q & {NCH{run_open}});

    for (genvar i = 0; i < NCH; i++) begin : g_disc
        disc_reg #(.DW(DW), .LSBZ(LSBZ)) u_disc (
            .clock   (clock),
            .reset_n (reset_n),
            .load    (accept && (op == OP_SET_DISC) && sel[i]),
            .data    (cmd.cmd_data),
            .value   (discriminator[i*DW +: DW])
        );
    end

    assign cmd.cmd_ready = ready_q;
    assign cmd.cmd_err   = err_q;
    assign ovf_count     = ovf_q;

endmodule

// File: tb/tb_control_mc.sv
// Bench for control_mc: command vector table with a scoreboard queue, then
// hand-written gating, overflow, reset and saturation sequences.
module tb_control_mc;
    import control_pkg::*;

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  chan;
        logic [7:0]  data;
        logic [3:0]  dis;
        logic [31:0] disc;
        logic        err;
        logic [15:0] ovf;
    } vec_t;

    typedef struct {
        logic [3:0]  dis;
        logic [31:0] disc;
        logic        err;
        logic [15:0] ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fifo_full;
    logic [3:0]  disableout;
    logic [31:0] discriminator;
    logic [15:0] ovf_count;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t vecs[16];
    exp_t sb[$];
    exp_t e;

    control_mc_if #(.DW(8)) bus();

    control_mc #(.NCH(4), .DW(8), .LSBZ(3), .HOLDOFF(16)) dut (
        .clock         (clk),
        .reset_n       (rst_n),
        .cmd           (bus.slave),
        .fifo_full     (fifo_full),
        .disableout    (disableout),
        .discriminator (discriminator),
        .ovf_count     (ovf_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [3:0] chan, input logic [7:0] data);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_chan  = chan;
        bus.cmd_data  = data;
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_NOP;
    endtask

    task automatic pulse();
        fifo_full = 1'b1;
        tick();
        fifo_full = 1'b0;
        tick();
    endtask

    // Entered just after fifo_full was dropped while the FSM sits in FULL.
    // The FSM sees the drop at the next edge, then stays in HOLD for 16 cycles.
    task automatic hold_window(input string tag);
        #1;
        check({tag, "_drop"}, 32'(disableout), 32'hF);
        for (int k = 0; k < 16; k++) begin
            tick();
            #1;
            check({tag, "_hold"}, 32'(disableout), 32'hF);
        end
        tick();
        #1;
        check({tag, "_open"}, 32'(disableout), 32'h0);
    endtask

    initial begin
        vecs[0]  = '{OP_ARM,        4'd2,  8'h00, 4'b1011, 32'h0000_0000, 1'b0, 16'd0};
        vecs[1]  = '{OP_SET_DISC,   4'd1,  8'hFF, 4'b1011, 32'h0000_F800, 1'b0, 16'd0};
        vecs[2]  = '{OP_SET_DISC,   4'd7,  8'hAB, 4'b1011, 32'h0000_F800, 1'b1, 16'd0};
        vecs[3]  = '{OP_SET_DISC,   4'd0,  8'h5C, 4'b1011, 32'h0000_F858, 1'b0, 16'd0};
        vecs[4]  = '{OP_ARM,        4'd4,  8'h00, 4'b1011, 32'h0000_F858, 1'b1, 16'd0};
        vecs[5]  = '{OP_RSVD,       4'd0,  8'h00, 4'b1011, 32'h0000_F858, 1'b1, 16'd0};
        vecs[6]  = '{OP_ARM,        4'd0,  8'h00, 4'b1010, 32'h0000_F858, 1'b0, 16'd0};
        vecs[7]  = '{OP_DISARM,     4'd2,  8'h00, 4'b1110, 32'h0000_F858, 1'b0, 16'd0};
        vecs[8]  = '{OP_NOP,        4'd3,  8'h00, 4'b1110, 32'h0000_F858, 1'b0, 16'd0};
        vecs[9]  = '{OP_SET_DISC,   4'd3,  8'h0F, 4'b1110, 32'h0800_F858, 1'b0, 16'd0};
        vecs[10] = '{OP_DISARM,     4'd15, 8'h00, 4'b1110, 32'h0800_F858, 1'b1, 16'd0};
        vecs[11] = '{OP_ARM_ALL,    4'd9,  8'h00, 4'b0000, 32'h0800_F858, 1'b0, 16'd0};
        vecs[12] = '{OP_DISARM_ALL, 4'd1,  8'h00, 4'b1111, 32'h0800_F858, 1'b0, 16'd0};
        vecs[13] = '{OP_ARM_ALL,    4'd0,  8'h00, 4'b0000, 32'h0800_F858, 1'b0, 16'd0};
        vecs[14] = '{OP_SET_DISC,   4'd2,  8'h37, 4'b0000, 32'h0830_F858, 1'b0, 16'd0};
        vecs[15] = '{OP_SET_DISC,   4'd1,  8'h07, 4'b0000, 32'h0830_0058, 1'b0, 16'd0};

        rst_n         = 1'b0;
        fifo_full     = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_NOP;
        bus.cmd_chan  = 4'd0;
        bus.cmd_data  = 8'h00;

        repeat (3) tick();
        check("rst_ready", 32'(bus.cmd_ready), 32'h0);
        check("rst_dis",   32'(disableout), 32'hF);
        check("rst_disc",  discriminator, 32'h0);
        check("rst_ovf",   32'(ovf_count), 32'h0);
        check("rst_err",   32'(bus.cmd_err), 32'h0);

        // A command held across the first edge after release must not be taken.
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_ARM;
        bus.cmd_chan  = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_NOP;
        check("ready_up",       32'(bus.cmd_ready), 32'h1);
        check("first_edge_arm", 32'(disableout), 32'hF);

        foreach (vecs[k]) begin
            sb.push_back('{vecs[k].dis, vecs[k].disc, vecs[k].err, vecs[k].ovf});
            issue(vecs[k].op, vecs[k].chan, vecs[k].data);
            #1;
            e = sb.pop_front();
            check("vec_dis",  32'(disableout), 32'(e.dis));
            check("vec_disc", discriminator, e.disc);
            check("vec_err",  32'(bus.cmd_err), 32'(e.err));
            check("vec_ovf",  32'(ovf_count), 32'(e.ovf));
            tick();
            #1;
            check("err_clear", 32'(bus.cmd_err), 32'h0);
        end

        // Full for five cycles: instant disable, one overflow, then 16-cycle holdoff.
        tick();
        fifo_full = 1'b1;
        #1;
        check("full_same_cycle", 32'(disableout), 32'hF);
        repeat (5) tick();
        check("ovf_one", 32'(ovf_count), 32'h1);
        fifo_full = 1'b0;
        hold_window("a");
        check("ovf_after_a", 32'(ovf_count), 32'h1);

        issue(OP_CLR_OVF, 4'd0, 8'h00);
        #1;
        check("clr_ovf", 32'(ovf_count), 32'h0);

        // Re-fill during HOLD must return to FULL and restart the holdoff.
        tick();
        fifo_full = 1'b1;
        tick();
        tick();
        fifo_full = 1'b0;
        repeat (6) tick();
        #1;
        check("b_in_hold", 32'(disableout), 32'hF);
        check("b_ovf1",    32'(ovf_count), 32'h1);
        fifo_full = 1'b1;
        tick();
        fifo_full = 1'b0;
        check("b_ovf2", 32'(ovf_count), 32'h2);
        hold_window("b");
        check("b_ovf_end", 32'(ovf_count), 32'h2);

        // Disarmed fill is not counted; arming during HOLD waits for RUN.
        issue(OP_DISARM_ALL, 4'd0, 8'h00);
        pulse();
        repeat (3) tick();
        issue(OP_ARM, 4'd3, 8'h00);
        #1;
        check("arm_in_hold",     32'(disableout), 32'hF);
        check("no_cnt_disarmed", 32'(ovf_count), 32'h2);
        repeat (20) tick();
        #1;
        check("arm_after_hold", 32'(disableout), 32'h7);

        // Clear coinciding with a new overflow leaves exactly one.
        issue(OP_ARM_ALL, 4'd0, 8'h00);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_CLR_OVF;
        fifo_full     = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_NOP;
        fifo_full     = 1'b0;
        check("clr_with_rise", 32'(ovf_count), 32'h1);
        check("clr_no_err",    32'(bus.cmd_err), 32'h0);
        hold_window("c");

        // Reset in the middle of HOLD with a command pending.
        fifo_full = 1'b1;
        tick();
        fifo_full = 1'b0;
        repeat (4) tick();
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_SET_DISC;
        bus.cmd_chan  = 4'd0;
        bus.cmd_data  = 8'hFF;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_dis",   32'(disableout), 32'hF);
        check("mid_rst_disc",  discriminator, 32'h0);
        check("mid_rst_ovf",   32'(ovf_count), 32'h0);
        check("mid_rst_ready", 32'(bus.cmd_ready), 32'h0);
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_NOP;
        tick();
        check("mid_rst_no_partial", discriminator, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        issue(OP_ARM_ALL, 4'd0, 8'h00);
        #1;
        check("rst_fsm_run", 32'(disableout), 32'h0);

        // Saturation: preload the counter near the top, then overflow past it.
        tick();
        force dut.ovf_q = 16'hFFFD;
        tick();
        release dut.ovf_q;
        check("sat_preload", 32'(ovf_count), 32'hFFFD);
        pulse();
        pulse();
        check("sat_reach", 32'(ovf_count), 32'hFFFF);
        pulse();
        pulse();
        check("sat_hold", 32'(ovf_count), 32'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
